// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage feeding an elastic FIFO.
//   Raw words are decoded combinationally on entry; the decoded record, its PC
//   and an illegal flag are stored, so the head is ready for register read.
//   Optional macro DECODE_QUEUE_RVM_EN adds M-extension decode (funct7=0000001).
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   flush             drop every queued entry and the word offered this cycle
//   in_valid/in_ready fetch handshake; in_ready depends on registered count only
//   in_pc, in_instr   PC and raw instruction word
//   out_valid/out_ready consumer handshake on the head entry
//   out_pc, out_instr, out_illegal  head entry (reset/idle values when empty)
//   count             number of occupied entries
package decode_queue_pkg;

`ifdef DECODE_QUEUE_RVM_EN
  typedef enum logic [4:0] {
    alu_nop, alu_add, alu_sub, alu_sll, alu_slt, alu_sltu, alu_xor,
    alu_srl, alu_sra, alu_or, alu_and,
    alu_mul, alu_mulh, alu_mulhsu, alu_mulhu,
    alu_div, alu_divu, alu_rem, alu_remu
  } alu_fn_t;
`else
  typedef enum logic [3:0] {
    alu_nop, alu_add, alu_sub, alu_sll, alu_slt, alu_sltu, alu_xor,
    alu_srl, alu_sra, alu_or, alu_and
  } alu_fn_t;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    alu_fn_t     alu_fn;
    logic        use_pc;
    logic        use_imm;
    logic        has_rd;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        is_branch;
    logic        is_mret;
  } instruction_t;

  // addi x0, x0, 0
  localparam instruction_t instr_nop = '{
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, funct3: 3'd0,
    alu_fn: alu_add, use_pc: 1'b0, use_imm: 1'b1, has_rd: 1'b0,
    is_load: 1'b0, is_store: 1'b0, is_jump: 1'b0, is_branch: 1'b0,
    is_mret: 1'b0
  };

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output instruction_t               out_instr,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic         illegal;
    logic [31:0]  pc;
    instruction_t instr;
  } entry_t;

  function automatic alu_fn_t base_alu(input logic [2:0] f3, input logic alt);
    alu_fn_t r;
    case (f3)
      3'b000:  r = alt ? alu_sub : alu_add;
      3'b001:  r = alu_sll;
      3'b010:  r = alu_slt;
      3'b011:  r = alu_sltu;
      3'b100:  r = alu_xor;
      3'b101:  r = alt ? alu_sra : alu_srl;
      3'b110:  r = alu_or;
      default: r = alu_and;
    endcase
    return r;
  endfunction

`ifdef DECODE_QUEUE_RVM_EN
  function automatic alu_fn_t m_alu(input logic [2:0] f3);
    alu_fn_t r;
    case (f3)
      3'b000:  r = alu_mul;
      3'b001:  r = alu_mulh;
      3'b010:  r = alu_mulhsu;
      3'b011:  r = alu_mulhu;
      3'b100:  r = alu_div;
      3'b101:  r = alu_divu;
      3'b110:  r = alu_rem;
      default: r = alu_remu;
    endcase
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------- decode
  logic [6:0]   opcode;
  logic [2:0]   f3;
  logic [6:0]   f7;
  logic         rd_nz;
  logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
  instruction_t dec;
  logic         dec_illegal;

  always_comb begin
    opcode = in_instr[6:0];
    f3     = in_instr[14:12];
    f7     = in_instr[31:25];
    rd_nz  = (in_instr[11:7] != 5'd0);
    imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
              in_instr[11:8], 1'b0};
    imm_u  = {in_instr[31:12], 12'd0};
    imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
              in_instr[30:21], 1'b0};

    dec        = '0;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = f3;
    dec.alu_fn = alu_nop;
    dec_illegal = 1'b0;

    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD: begin
          dec.imm     = imm_i;
          dec.use_imm = 1'b1;
          dec.has_rd  = rd_nz;
          dec.is_load = 1'b1;
          dec.alu_fn  = alu_add;
          dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        OP_STORE: begin
          dec.imm      = imm_s;
          dec.use_imm  = 1'b1;
          dec.is_store = 1'b1;
          dec.alu_fn   = alu_add;
          dec_illegal  = (f3 > 3'b010);
        end
        OP_BRANCH: begin
          dec.imm       = imm_b;
          dec.is_branch = 1'b1;
          dec.alu_fn    = alu_nop;
          dec_illegal   = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OP_JALR: begin
          dec.imm     = imm_i;
          dec.use_imm = 1'b1;
          dec.has_rd  = rd_nz;
          dec.is_jump = 1'b1;
          dec.alu_fn  = alu_add;
          dec_illegal = (f3 != 3'b000);
        end
        OP_JAL: begin
          dec.imm     = imm_j;
          dec.use_imm = 1'b1;
          dec.use_pc  = 1'b1;
          dec.has_rd  = rd_nz;
          dec.is_jump = 1'b1;
          dec.alu_fn  = alu_add;
        end
        OP_LUI: begin
          dec.imm     = imm_u;
          dec.use_imm = 1'b1;
          dec.has_rd  = rd_nz;
          dec.alu_fn  = alu_add;
        end
        OP_AUIPC: begin
          dec.imm     = imm_u;
          dec.use_imm = 1'b1;
          dec.use_pc  = 1'b1;
          dec.has_rd  = rd_nz;
          dec.alu_fn  = alu_add;
        end
        OP_IMM: begin
          dec.imm     = imm_i;
          dec.use_imm = 1'b1;
          dec.has_rd  = rd_nz;
          // Only shifts constrain the upper bits; srai is the single alternate form.
          if (f3 == 3'b001) begin
            dec.alu_fn  = alu_sll;
            dec_illegal = (f7 != 7'b0000000);
          end else if (f3 == 3'b101) begin
            dec.alu_fn  = base_alu(f3, f7[5]);
            dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end else begin
            dec.alu_fn = base_alu(f3, 1'b0);
          end
        end
        OP_OP: begin
          dec.has_rd = rd_nz;
          if (f7 == 7'b0000000) begin
            dec.alu_fn = base_alu(f3, 1'b0);
          end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
            dec.alu_fn = base_alu(f3, 1'b1);
`ifdef DECODE_QUEUE_RVM_EN
          end else if (f7 == 7'b0000001) begin
            dec.alu_fn = m_alu(f3);
`endif
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_SYSTEM: begin
          dec.imm     = imm_i;
          dec.use_imm = 1'b1;
          dec.alu_fn  = alu_nop;
          dec.is_mret = 1'b1;
          dec_illegal = (in_instr != 32'h3020_0073);
        end
        default: dec_illegal = 1'b1;
      endcase
    end

    if (dec_illegal) dec = instr_nop;
  end

  // ------------------------------------------------------------------ FIFO
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;
  entry_t           head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  // flush wins over both handshakes, so neither side advances that cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{illegal: dec_illegal, pc: in_pc, instr: dec};
  end

  // Storage is not reset; empty-queue output values come from this mux.
  always_comb begin
    head        = mem[rd_ptr];
    out_pc      = RESET_PC_TAG;
    out_instr   = instr_nop;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = head.pc;
      out_instr   = head.instr;
      out_illegal = head.illegal;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Randomised scoreboard bench for decode_queue: the driver predicts acceptance
// and pushes reference-decoded entries; a negedge monitor checks the head,
// flags and count against the scoreboard.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TAG   = 32'hDEAD_0000;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_pc = '0;
  logic [31:0]        in_instr = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [31:0]        out_pc;
  instruction_t       out_instr;
  logic               out_illegal;
  logic [2:0]         count;

  decode_queue #(.DEPTH(DEPTH), .RESET_PC_TAG(TAG)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  pc;
    instruction_t d;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   occ = 0;
  bit   mon_en = 1'b0;

  alu_fn_t alu_tbl [8] = '{alu_add, alu_sll, alu_slt, alu_sltu,
                           alu_xor, alu_srl, alu_or, alu_and};
`ifdef DECODE_QUEUE_RVM_EN
  alu_fn_t mul_tbl [8] = '{alu_mul, alu_mulh, alu_mulhsu, alu_mulhu,
                           alu_div, alu_divu, alu_rem, alu_remu};
`endif
  logic [6:0] opc_tbl [11] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37,
                               7'h17, 7'h13, 7'h33, 7'h73, 7'h0F};

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode: classify by format, then derive fields arithmetically.
  function automatic exp_t ref_model(input logic [31:0] pc, input logic [31:0] w);
    exp_t         r;
    instruction_t d;
    logic [6:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    byte          fmt;
    bit           legal;
    bit           writes;
    alu_fn_t      fn;
    logic [31:0]  sx;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    sx  = ($signed(w) >>> 31);
    d = '0;
    d.rd = w[11:7];
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    d.funct3 = f3;
    legal = (w[1:0] == 2'b11);
    writes = 1'b0;
    fn = alu_nop;
    fmt = "R";
    case (opc)
      7'h03: begin fmt = "I"; writes = 1; d.is_load = 1; fn = alu_add;
                   if (f3 inside {3'd3, 3'd6, 3'd7}) legal = 0; end
      7'h23: begin fmt = "S"; d.is_store = 1; fn = alu_add; if (f3 > 3'd2) legal = 0; end
      7'h63: begin fmt = "B"; d.is_branch = 1; if (f3 inside {3'd2, 3'd3}) legal = 0; end
      7'h67: begin fmt = "I"; writes = 1; d.is_jump = 1; fn = alu_add; if (f3 != 0) legal = 0; end
      7'h6F: begin fmt = "J"; writes = 1; d.is_jump = 1; d.use_pc = 1; fn = alu_add; end
      7'h37: begin fmt = "U"; writes = 1; fn = alu_add; end
      7'h17: begin fmt = "U"; writes = 1; d.use_pc = 1; fn = alu_add; end
      7'h13: begin
        fmt = "I"; writes = 1; fn = alu_tbl[f3];
        if (f3 == 3'd1 && f7 != 7'h00) legal = 0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) fn = alu_sra;
          else if (f7 != 7'h00) legal = 0;
        end
      end
      7'h33: begin
        fmt = "R"; writes = 1;
        if (f7 == 7'h00) fn = alu_tbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) fn = alu_sub;
        else if (f7 == 7'h20 && f3 == 3'd5) fn = alu_sra;
`ifdef DECODE_QUEUE_RVM_EN
        else if (f7 == 7'h01) fn = mul_tbl[f3];
`endif
        else legal = 0;
      end
      7'h73: begin fmt = "I"; d.is_mret = 1; if (w != 32'h3020_0073) legal = 0; end
      default: legal = 0;
    endcase
    case (fmt)
      "I": d.imm = $signed(w) >>> 20;
      "S": d.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
      "B": d.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      "U": d.imm = w & 32'hFFFF_F000;
      "J": d.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: d.imm = 32'd0;
    endcase
    d.use_imm = !(fmt inside {"R", "B"});
    d.has_rd  = writes && (w[11:7] != 5'd0);
    d.alu_fn  = fn;
    r.pc  = pc;
    r.ill = !legal;
    r.d   = legal ? d : instr_nop;
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) w[6:0] = opc_tbl[k];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w = 32'h3020_0073;
    return w;
  endfunction

  // Monitor: compares at the negedge, then retires whatever the next edge consumes.
  always @(negedge clk) begin
    if (mon_en) begin
      occ = sb.size();
      chk("out_valid", 96'(out_valid), 96'(occ != 0));
      chk("count", 96'(count), 96'(occ));
      chk("in_ready", 96'(in_ready), 96'(occ != DEPTH));
      if (occ != 0) begin
        chk("head_pc", 96'(out_pc), 96'(sb[0].pc));
        chk("head_instr", 96'(out_instr), 96'(sb[0].d));
        chk("head_illegal", 96'(out_illegal), 96'(sb[0].ill));
      end else begin
        chk("idle_pc", 96'(out_pc), 96'(TAG));
        chk("idle_instr", 96'(out_instr), 96'(instr_nop));
        chk("idle_illegal", 96'(out_illegal), 96'(1'b0));
      end
      if (flush) sb.delete();
      else if (occ != 0 && out_ready) void'(sb.pop_front());
    end
  end

  // Driver: one cycle per call; acceptance predicted from the model occupancy.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] w,
                      input bit rdy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = w;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (mon_en && v && !fl && occ < DEPTH) sb.push_back(ref_model(pc, w));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) step(0, 0, 0, 1, 0);
    chk("drain_empty", 96'(sb.size()), 96'(0));
  endtask

  initial begin
    #12;
    chk("rst_valid", 96'(out_valid), 96'(1'b0));
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_pc", 96'(out_pc), 96'(TAG));
    chk("rst_instr", 96'(out_instr), 96'(instr_nop));
    chk("rst_illegal", 96'(out_illegal), 96'(1'b0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(0, 0, 0, 1, 0);

    // addi x1, x2, -1
    step(1, 32'h100, 32'hFFF1_0093, 1, 0);
    chk("t1_valid", 96'(out_valid), 96'(1'b1));
    chk("t1_rd", 96'(out_instr.rd), 96'(5'd1));
    chk("t1_rs1", 96'(out_instr.rs1), 96'(5'd2));
    chk("t1_imm", 96'(out_instr.imm), 96'(32'hFFFF_FFFF));
    chk("t1_alu", 96'(out_instr.alu_fn), 96'(alu_add));
    chk("t1_use_imm", 96'(out_instr.use_imm), 96'(1'b1));
    chk("t1_has_rd", 96'(out_instr.has_rd), 96'(1'b1));
    chk("t1_pc", 96'(out_pc), 96'(32'h100));
    step(0, 0, 0, 1, 0);
    chk("t1_popped", 96'(out_valid), 96'(1'b0));

    // sw x5, 8(x6) then beq x1, x2, -4
    step(1, 32'h200, 32'h0053_2423, 0, 0);
    step(1, 32'h204, 32'hFE20_8EE3, 0, 0);
    chk("t2_store", 96'(out_instr.is_store), 96'(1'b1));
    chk("t2_rs1", 96'(out_instr.rs1), 96'(5'd6));
    chk("t2_rs2", 96'(out_instr.rs2), 96'(5'd5));
    chk("t2_imm", 96'(out_instr.imm), 96'(32'd8));
    chk("t2_f3", 96'(out_instr.funct3), 96'(3'b010));
    step(0, 0, 0, 1, 0);
    chk("t2_branch", 96'(out_instr.is_branch), 96'(1'b1));
    chk("t2_brs1", 96'(out_instr.rs1), 96'(5'd1));
    chk("t2_brs2", 96'(out_instr.rs2), 96'(5'd2));
    chk("t2_bimm", 96'(out_instr.imm), 96'(32'hFFFF_FFFC));
    chk("t2_bhas_rd", 96'(out_instr.has_rd), 96'(1'b0));
    drain();

    // Fill, refuse a fifth word, then stream through the pointer wrap.
    for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i * 4), 32'h0000_0093 | (32'(i) << 20), 0, 0);
    chk("t3_count", 96'(count), 96'(4));
    chk("t3_in_ready", 96'(in_ready), 96'(1'b0));
    for (int i = 0; i < 8; i++) step(1, 32'h400 + 32'(i * 4), rand_word(), 1, 0);
    drain();

    // Flush at count 3 with a word offered in the same cycle.
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), rand_word(), 0, 0);
    chk("t4_count3", 96'(count), 96'(3));
    step(1, 32'h50C, 32'h0010_0093, 1, 1);
    chk("t4_count0", 96'(count), 96'(0));
    chk("t4_valid0", 96'(out_valid), 96'(1'b0));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

    // Illegal / mret ordering.
    step(1, 32'h600, 32'h0000_0000, 0, 0);
    step(1, 32'h604, 32'h3020_0073, 0, 0);
    step(1, 32'h608, 32'h1050_0073, 0, 0);
    chk("t5_ill0", 96'(out_illegal), 96'(1'b1));
    step(0, 0, 0, 1, 0);
    chk("t5_ill1", 96'(out_illegal), 96'(1'b0));
    chk("t5_mret", 96'(out_instr.is_mret), 96'(1'b1));
    step(0, 0, 0, 1, 0);
    chk("t5_ill2", 96'(out_illegal), 96'(1'b1));
    drain();

    // mul x3, x1, x2
    step(1, 32'h700, 32'h0220_81B3, 0, 0);
`ifdef DECODE_QUEUE_RVM_EN
    chk("t6_alu", 96'(out_instr.alu_fn), 96'(alu_mul));
    chk("t6_rd", 96'(out_instr.rd), 96'(5'd3));
    chk("t6_ill", 96'(out_illegal), 96'(1'b0));
`else
    chk("t6_ill", 96'(out_illegal), 96'(1'b1));
    chk("t6_nop", 96'(out_instr), 96'(instr_nop));
`endif
    drain();

    // Asynchronous reset with entries queued.
    step(1, 32'h800, rand_word(), 0, 0);
    step(1, 32'h804, rand_word(), 0, 0);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("arst_count", 96'(count), 96'(0));
    chk("arst_valid", 96'(out_valid), 96'(1'b0));
    sb.delete();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, rand_word(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
    end
    drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
